// File: rtl/memoria_dados_byte.sv
// memoria_dados_byte: byte-addressable single-clock data memory with wait states and alignment checking
module memoria_dados_byte #(
   parameter int ADDR_WIDTH  = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic                  Clock,
   input  logic                  Reset_n,
   input  logic                  Mem_Read,
   input  logic                  Mem_Write,
   input  logic [ADDR_WIDTH-1:0] Endereco,
   input  logic [1:0]            Tamanho,
   input  logic                  Com_Sinal,
   input  logic [31:0]           Write_Data,
   output logic [31:0]           Read_Data,
   output logic                  Ready,
   output logic                  Valid,
   output logic                  Erro_Alinhamento
);
   typedef enum logic {OCIOSO, ESPERA} estado_t;
   localparam logic [3:0] CNT_INI = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
   localparam bit SEM_ESPERA = (WAIT_STATES == 0);
   logic [31:0] mem [0:2**(ADDR_WIDTH-2)-1];
   estado_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [1:0] tam_q;
   logic sinal_q, wr_q;
   logic [31:0] wdata_q, rdata_q;
   logic valid_q, erro_q;
   logic accept, exec, misal;
   logic [ADDR_WIDTH-1:0] ex_addr;
   logic [1:0] ex_tam, lane;
   logic ex_sinal, ex_wr;
   logic [31:0] ex_wdata, word_rd, word_wr, bit_mask, wrep, sh, load_val;
   logic [3:0] byte_en;
   // With no wait states the access runs straight off the live inputs; otherwise off the captured copy
   always_comb begin
      accept   = Ready && (Mem_Read || Mem_Write);
      ex_addr  = SEM_ESPERA ? Endereco : addr_q;
      ex_tam   = SEM_ESPERA ? Tamanho : tam_q;
      ex_sinal = SEM_ESPERA ? Com_Sinal : sinal_q;
      ex_wdata = SEM_ESPERA ? Write_Data : wdata_q;
      ex_wr    = SEM_ESPERA ? Mem_Write : wr_q;
      exec     = Reset_n && (SEM_ESPERA ? accept : (state_q == ESPERA && cnt_q == 4'd0));
      lane     = ex_addr[1:0];
      misal    = (ex_tam == 2'b11) || (ex_tam == 2'b01 && lane[0]) || (ex_tam == 2'b10 && lane != 2'b00);
      word_rd  = mem[ex_addr[ADDR_WIDTH-1:2]];
      byte_en  = (ex_tam == 2'b00) ? (4'b0001 << lane) : (ex_tam == 2'b01) ? (4'b0011 << {lane[1], 1'b0}) : 4'b1111;
      bit_mask = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};
      wrep     = (ex_tam == 2'b00) ? {4{ex_wdata[7:0]}} : (ex_tam == 2'b01) ? {2{ex_wdata[15:0]}} : ex_wdata;
      word_wr  = (word_rd & ~bit_mask) | (wrep & bit_mask);
      sh       = word_rd >> {lane, 3'b000};
      load_val = (ex_tam == 2'b00) ? {{24{ex_sinal & sh[7]}}, sh[7:0]} :
                 (ex_tam == 2'b01) ? {{16{ex_sinal & sh[15]}}, sh[15:0]} : word_rd;
   end
   // Storage array: lane-masked read-modify-write, never reset
   always_ff @(posedge Clock) begin
      if (exec && ex_wr && !misal) mem[ex_addr[ADDR_WIDTH-1:2]] <= word_wr;
   end
   // FSM state register and request capture
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= OCIOSO;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         tam_q   <= 2'b00;
         sinal_q <= 1'b0;
         wr_q    <= 1'b0;
         wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            addr_q  <= Endereco;
            tam_q   <= Tamanho;
            sinal_q <= Com_Sinal;
            wr_q    <= Mem_Write;
            wdata_q <= Write_Data;
         end
      end
   end
   // Next state: wait in ESPERA counting down, execute when the counter reaches zero
   always_comb begin
      state_d = (state_q == OCIOSO) ? ((accept && !SEM_ESPERA) ? ESPERA : OCIOSO) : ((cnt_q == 4'd0) ? OCIOSO : ESPERA);
      cnt_d   = (state_q == OCIOSO) ? (accept ? CNT_INI : cnt_q) : ((cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1);
   end
   // Ready is a pure function of the FSM state
   always_comb begin
      Ready = (state_q == OCIOSO);
   end
   // Completion outputs: load result or zero on error, one-cycle Valid pulse
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         rdata_q <= 32'd0;
         valid_q <= 1'b0;
         erro_q  <= 1'b0;
      end else begin
         valid_q <= exec;
         erro_q  <= exec && misal;
         if (exec && (misal || !ex_wr)) rdata_q <= misal ? 32'd0 : load_val;
      end
   end
   assign Read_Data        = rdata_q;
   assign Valid            = valid_q;
   assign Erro_Alinhamento = erro_q;
endmodule

// File: tb/tb_memoria_dados_byte.sv
// tb_memoria_dados_byte: directed checks of zero-wait and three-wait-state memory instances
module tb_memoria_dados_byte;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int checks = 0;
   int errors = 0;
   logic rst0_n, rd0, wr0, s0, rdy0, vld0, err0;
   logic [15:0] a0;
   logic [1:0] t0;
   logic [31:0] wd0, rdat0;
   logic rst3_n, rd3, wr3, s3, rdy3, vld3, err3;
   logic [15:0] a3;
   logic [1:0] t3;
   logic [31:0] wd3, rdat3;
   memoria_dados_byte #(.ADDR_WIDTH(16), .WAIT_STATES(0)) u0 (
      .Clock(clk), .Reset_n(rst0_n), .Mem_Read(rd0), .Mem_Write(wr0), .Endereco(a0),
      .Tamanho(t0), .Com_Sinal(s0), .Write_Data(wd0), .Read_Data(rdat0), .Ready(rdy0),
      .Valid(vld0), .Erro_Alinhamento(err0));
   memoria_dados_byte #(.ADDR_WIDTH(16), .WAIT_STATES(3)) u3 (
      .Clock(clk), .Reset_n(rst3_n), .Mem_Read(rd3), .Mem_Write(wr3), .Endereco(a3),
      .Tamanho(t3), .Com_Sinal(s3), .Write_Data(wd3), .Read_Data(rdat3), .Ready(rdy3),
      .Valid(vld3), .Erro_Alinhamento(err3));
   task automatic op0(input logic r, input logic w, input logic [15:0] a, input logic [1:0] t, input logic s, input logic [31:0] d);
      @(negedge clk);
      rd0 = r; wr0 = w; a0 = a; t0 = t; s0 = s; wd0 = d;
      @(posedge clk);
      #1;
   endtask
   task automatic idle0();
      @(negedge clk);
      rd0 = 1'b0; wr0 = 1'b0;
      @(posedge clk);
      #1;
   endtask
   task automatic op3(input logic r, input logic w, input logic [15:0] a, input logic [1:0] t, input logic s, input logic [31:0] d);
      @(negedge clk);
      rd3 = r; wr3 = w; a3 = a; t3 = t; s3 = s; wd3 = d;
      @(posedge clk);
      #1;
   endtask
   task automatic idle3();
      @(negedge clk);
      rd3 = 1'b0; wr3 = 1'b0;
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      checks++; if (rdat0 !== 32'd0) begin errors++; $display("FAIL reset_rdata0 got %h exp %h", rdat0, 32'd0); end
      checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_ready0 got %b exp 1", rdy0); end
      checks++; if (vld0 !== 1'b0 || err0 !== 1'b0) begin errors++; $display("FAIL reset_valid_err0 got %b%b exp 00", vld0, err0); end
      checks++; if (rdat3 !== 32'd0) begin errors++; $display("FAIL reset_rdata3 got %h exp %h", rdat3, 32'd0); end
      checks++; if (rdy3 !== 1'b1 || vld3 !== 1'b0 || err3 !== 1'b0) begin errors++; $display("FAIL reset_ctrl3 got %b%b%b exp 100", rdy3, vld3, err3); end
   endtask
   task automatic test_word();
      op0(1'b0, 1'b1, 16'h0010, 2'b10, 1'b0, 32'h12345678);
      checks++; if (vld0 !== 1'b1 || err0 !== 1'b0 || rdy0 !== 1'b1) begin errors++; $display("FAIL word_store_ctrl got v%b e%b r%b exp v1 e0 r1", vld0, err0, rdy0); end
      checks++; if (rdat0 !== 32'd0) begin errors++; $display("FAIL word_store_rdata got %h exp %h", rdat0, 32'd0); end
      op0(1'b1, 1'b0, 16'h0010, 2'b10, 1'b1, 32'h0);
      checks++; if (vld0 !== 1'b1 || rdy0 !== 1'b1) begin errors++; $display("FAIL word_load_ctrl got v%b r%b exp v1 r1", vld0, rdy0); end
      checks++; if (rdat0 !== 32'h12345678) begin errors++; $display("FAIL word_load got %h exp %h", rdat0, 32'h12345678); end
      idle0();
      checks++; if (vld0 !== 1'b0 || rdat0 !== 32'h12345678) begin errors++; $display("FAIL word_idle got v%b %h exp v0 %h", vld0, rdat0, 32'h12345678); end
   endtask
   task automatic test_byte();
      op0(1'b0, 1'b1, 16'h0013, 2'b00, 1'b0, 32'h000000AB);
      op0(1'b1, 1'b0, 16'h0013, 2'b00, 1'b1, 32'h0);
      checks++; if (rdat0 !== 32'hFFFFFFAB) begin errors++; $display("FAIL byte_signed got %h exp %h", rdat0, 32'hFFFFFFAB); end
      op0(1'b1, 1'b0, 16'h0013, 2'b00, 1'b0, 32'h0);
      checks++; if (rdat0 !== 32'h000000AB) begin errors++; $display("FAIL byte_unsigned got %h exp %h", rdat0, 32'h000000AB); end
      op0(1'b1, 1'b0, 16'h0010, 2'b10, 1'b0, 32'h0);
      checks++; if (rdat0 !== 32'hAB345678) begin errors++; $display("FAIL byte_word got %h exp %h", rdat0, 32'hAB345678); end
      op0(1'b1, 1'b0, 16'h0011, 2'b00, 1'b0, 32'h0);
      checks++; if (rdat0 !== 32'h00000056) begin errors++; $display("FAIL byte_lane1 got %h exp %h", rdat0, 32'h00000056); end
      idle0();
   endtask
   task automatic test_half();
      op0(1'b0, 1'b1, 16'h0012, 2'b01, 1'b0, 32'h00008001);
      op0(1'b1, 1'b0, 16'h0012, 2'b01, 1'b1, 32'h0);
      checks++; if (rdat0 !== 32'hFFFF8001 || err0 !== 1'b0) begin errors++; $display("FAIL half_signed got %h e%b exp %h e0", rdat0, err0, 32'hFFFF8001); end
      op0(1'b1, 1'b0, 16'h0011, 2'b01, 1'b1, 32'h0);
      checks++; if (vld0 !== 1'b1 || err0 !== 1'b1 || rdat0 !== 32'd0) begin errors++; $display("FAIL half_misaligned got v%b e%b %h exp v1 e1 0", vld0, err0, rdat0); end
      op0(1'b1, 1'b0, 16'h0010, 2'b10, 1'b0, 32'h0);
      checks++; if (rdat0 !== 32'h80015678 || err0 !== 1'b0) begin errors++; $display("FAIL half_word got %h e%b exp %h e0", rdat0, err0, 32'h80015678); end
      op0(1'b0, 1'b1, 16'h0010, 2'b11, 1'b0, 32'hFFFFFFFF);
      checks++; if (err0 !== 1'b1 || rdat0 !== 32'd0) begin errors++; $display("FAIL illegal_size got e%b %h exp e1 0", err0, rdat0); end
      op0(1'b0, 1'b1, 16'h0012, 2'b10, 1'b0, 32'hFFFFFFFF);
      checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL word_misaligned got e%b exp e1", err0); end
      op0(1'b1, 1'b0, 16'h0010, 2'b10, 1'b0, 32'h0);
      checks++; if (rdat0 !== 32'h80015678) begin errors++; $display("FAIL error_no_write got %h exp %h", rdat0, 32'h80015678); end
      idle0();
   endtask
   task automatic test_both_ops();
      op0(1'b1, 1'b1, 16'h0004, 2'b10, 1'b0, 32'hCAFEF00D);
      checks++; if (vld0 !== 1'b1 || err0 !== 1'b0 || rdat0 !== 32'h80015678) begin errors++; $display("FAIL both_ops got v%b e%b %h exp v1 e0 %h", vld0, err0, rdat0, 32'h80015678); end
      op0(1'b1, 1'b0, 16'h0004, 2'b10, 1'b0, 32'h0);
      checks++; if (rdat0 !== 32'hCAFEF00D) begin errors++; $display("FAIL both_ops_load got %h exp %h", rdat0, 32'hCAFEF00D); end
      idle0();
   endtask
   task automatic test_wait();
      op3(1'b0, 1'b1, 16'h0030, 2'b10, 1'b0, 32'h11223344);
      checks++; if (rdy3 !== 1'b0 || vld3 !== 1'b0) begin errors++; $display("FAIL wait_e0 got r%b v%b exp r0 v0", rdy3, vld3); end
      op3(1'b1, 1'b0, 16'h0030, 2'b10, 1'b0, 32'h0);
      checks++; if (rdy3 !== 1'b0 || vld3 !== 1'b0) begin errors++; $display("FAIL wait_e1 got r%b v%b exp r0 v0", rdy3, vld3); end
      op3(1'b1, 1'b0, 16'h0030, 2'b10, 1'b0, 32'h0);
      checks++; if (rdy3 !== 1'b0 || vld3 !== 1'b0) begin errors++; $display("FAIL wait_e2 got r%b v%b exp r0 v0", rdy3, vld3); end
      idle3();
      checks++; if (rdy3 !== 1'b1 || vld3 !== 1'b1 || err3 !== 1'b0 || rdat3 !== 32'd0) begin errors++; $display("FAIL wait_e3 got r%b v%b e%b %h exp r1 v1 e0 0", rdy3, vld3, err3, rdat3); end
      for (int i = 0; i < 4; i++) begin
         idle3();
         checks++; if (vld3 !== 1'b0 || rdy3 !== 1'b1) begin errors++; $display("FAIL wait_ignored cycle %0d got v%b r%b exp v0 r1", i, vld3, rdy3); end
      end
      op3(1'b1, 1'b0, 16'h0030, 2'b10, 1'b0, 32'h0);
      idle3();
      idle3();
      checks++; if (vld3 !== 1'b0) begin errors++; $display("FAIL wait_early_valid got %b exp 0", vld3); end
      idle3();
      checks++; if (vld3 !== 1'b1 || rdat3 !== 32'h11223344) begin errors++; $display("FAIL wait_load got v%b %h exp v1 %h", vld3, rdat3, 32'h11223344); end
   endtask
   task automatic test_reset_abort();
      op3(1'b0, 1'b1, 16'h0020, 2'b10, 1'b0, 32'h00000000);
      repeat (3) idle3();
      op3(1'b0, 1'b1, 16'h0020, 2'b10, 1'b0, 32'hDEADBEEF);
      idle3();
      #2 rst3_n = 1'b0;
      #1;
      checks++; if (rdy3 !== 1'b1 || vld3 !== 1'b0 || rdat3 !== 32'd0) begin errors++; $display("FAIL abort_reset got r%b v%b %h exp r1 v0 0", rdy3, vld3, rdat3); end
      @(negedge clk);
      rst3_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         idle3();
         checks++; if (vld3 !== 1'b0) begin errors++; $display("FAIL abort_no_valid cycle %0d got %b exp 0", i, vld3); end
      end
      op3(1'b1, 1'b0, 16'h0020, 2'b10, 1'b0, 32'h0);
      repeat (3) idle3();
      checks++; if (vld3 !== 1'b1 || rdat3 !== 32'h00000000) begin errors++; $display("FAIL abort_no_write got v%b %h exp v1 0", vld3, rdat3); end
   endtask
   initial begin
      rst0_n = 1'b0; rd0 = 1'b0; wr0 = 1'b0; a0 = '0; t0 = 2'b00; s0 = 1'b0; wd0 = '0;
      rst3_n = 1'b0; rd3 = 1'b0; wr3 = 1'b0; a3 = '0; t3 = 2'b00; s3 = 1'b0; wd3 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst0_n = 1'b1;
      rst3_n = 1'b1;
      #1;
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_both_ops();
      test_wait();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
